uart_packet_tx: RTL and testbench

Packet framer that sits directly upstream of the UART byte transmitter. It buffers up to MAX_LEN payload bytes written by the host logic. On command it emits a framed packet to the transmitter one byte at a time: SYNC, LEN, payload, CHECKSUM. It drives the transmitter's data-valid/byte inputs and paces itself on the transmitter's done pulse.

---
 rtl/uart_packet_tx.sv | 170 +++++++++++++++++
 tb/tb_uart_packet_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// rtl/uart_packet_tx.sv - buffers payload bytes and frames them as SYNC, LEN, payload, CSUM
// toward a UART byte transmitter, pacing on its done pulse.
module uart_packet_tx #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Wr_En,
  input  logic [7:0]                   i_Wr_Data,
  input  logic                         i_Send,
  input  logic                         i_Tx_Active,
  input  logic                         i_Tx_Done,
  output logic                         o_Tx_DV,
  output logic [7:0]                   o_Tx_Byte,
  output logic                         o_Busy,
  output logic [$clog2(MAX_LEN+1)-1:0] o_Buf_Count,
  output logic                         o_Buf_Full,
  output logic                         o_Wr_Err,
  output logic                         o_Pkt_Done
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {F_SYNC, F_LEN, F_DATA, F_CSUM} field_t;

  logic [7:0] buf_mem [0:MAX_LEN-1];

  state_t        state_q, state_d;
  field_t        field_q, field_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] rd_q, rd_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          busy_q, busy_d;
  logic          full_q, full_d;
  logic          wr_err_q, wr_err_d;
  logic          pkt_done_q, pkt_done_d;

  logic          wr_ok;
  logic [CW-1:0] count_wr;
  logic [7:0]    field_byte;

  always_comb begin
    wr_ok    = i_Wr_En && (state_q == S_IDLE) && (count_q != CW'(MAX_LEN));
    count_wr = count_q + CW'(wr_ok);
  end

  always_comb begin
    field_byte = SYNC_BYTE;
    case (field_q)
      F_SYNC:  field_byte = SYNC_BYTE;
      F_LEN:   field_byte = 8'(len_q);
      F_DATA:  field_byte = buf_mem[rd_q[AW-1:0]];
      F_CSUM:  field_byte = (~csum_q) + 8'd1;
      default: field_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    count_d    = count_wr;
    len_d      = len_q;
    rd_d       = rd_q;
    csum_d     = csum_q;
    byte_d     = byte_q;
    dv_d       = 1'b0;
    wr_err_d   = i_Wr_En && !wr_ok;
    pkt_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Send && (count_wr != '0)) begin
          len_d   = count_wr;
          csum_d  = 8'd0;
          rd_d    = '0;
          field_d = F_SYNC;
          // SYNC goes out straight from IDLE so the strobe follows the request by one cycle
          if (!i_Tx_Active) begin
            dv_d    = 1'b1;
            byte_d  = SYNC_BYTE;
            state_d = S_WAIT;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!i_Tx_Active) begin
          dv_d    = 1'b1;
          byte_d  = field_byte;
          state_d = S_WAIT;
          if ((field_q == F_LEN) || (field_q == F_DATA)) csum_d = csum_q + field_byte;
        end
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          state_d = S_ISSUE;
          case (field_q)
            F_SYNC: field_d = F_LEN;
            F_LEN:  field_d = F_DATA;
            F_DATA: begin
              rd_d = rd_q + CW'(1);
              if (rd_q == len_q - CW'(1)) field_d = F_CSUM;
            end
            default: begin
              state_d    = S_DONE;
              pkt_done_d = 1'b1;
            end
          endcase
        end
      end
      default: begin
        count_d = '0;
        rd_d    = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    full_d = (count_d == CW'(MAX_LEN));
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      field_q    <= F_SYNC;
      count_q    <= '0;
      len_q      <= '0;
      rd_q       <= '0;
      csum_q     <= 8'd0;
      byte_q     <= 8'd0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rd_q       <= rd_d;
      csum_q     <= csum_d;
      byte_q     <= byte_d;
      dv_q       <= dv_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      wr_err_q   <= wr_err_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Payload storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge i_Clock) begin
    if (wr_ok) buf_mem[count_q[AW-1:0]] <= i_Wr_Data;
  end

  assign o_Tx_DV     = dv_q;
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = busy_q;
  assign o_Buf_Count = count_q;
  assign o_Buf_Full  = full_q;
  assign o_Wr_Err    = wr_err_q;
  assign o_Pkt_Done  = pkt_done_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb/tb_uart_packet_tx.sv - directed bench for uart_packet_tx with a 10-cycle transmitter model
// and a per-cycle packet-level reference model.
module tb_uart_packet_tx;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       i_Reset = 1'b1, i_Wr_En = 1'b0, i_Send = 1'b0;
  logic       i_Tx_Active = 1'b0, i_Tx_Done = 1'b0;
  logic [7:0] i_Wr_Data = 8'h00;
  logic       o_Tx_DV, o_Busy, o_Buf_Full, o_Wr_Err, o_Pkt_Done;
  logic [7:0] o_Tx_Byte;
  logic [4:0] o_Buf_Count;

  always #5 clk = ~clk;

  uart_packet_tx dut (
    .i_Clock(clk), .i_Reset(i_Reset), .i_Wr_En(i_Wr_En), .i_Wr_Data(i_Wr_Data),
    .i_Send(i_Send), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .o_Busy(o_Busy), .o_Buf_Count(o_Buf_Count),
    .o_Buf_Full(o_Buf_Full), .o_Wr_Err(o_Wr_Err), .o_Pkt_Done(o_Pkt_Done)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered bytes, the bytes still owed to the transmitter, and when the
  // next strobe may appear (send: same edge if idle line; done: the following edge).
  logic [7:0] m_buf[$];
  logic [7:0] m_bytes[$];
  bit         m_busy = 0, m_pend = 0, m_wait = 0, m_fin = 0;
  int         m_earliest = 0, edge_n = 0;
  logic       s_wr, s_send, s_act, s_done, s_rst;
  logic [7:0] s_data, sum, exp_byte;
  logic       wr_ok, exp_err, exp_pd, exp_dv;

  always @(posedge clk) begin
    s_rst = i_Reset; s_wr = i_Wr_En; s_data = i_Wr_Data;
    s_send = i_Send; s_act = i_Tx_Active; s_done = i_Tx_Done;
    #1;
    edge_n++;
    exp_err = 0; exp_pd = 0; exp_dv = 0; exp_byte = 8'h00;
    if (s_rst) begin
      m_buf.delete(); m_bytes.delete();
      m_busy = 0; m_pend = 0; m_wait = 0; m_fin = 0;
      chk("rst_byte", o_Tx_Byte, 0);
    end else begin
      wr_ok = s_wr && !m_busy && (m_buf.size() < 16);
      if (s_wr && !wr_ok) exp_err = 1;
      if (wr_ok) m_buf.push_back(s_data);
      if (s_send && !m_busy && m_buf.size() > 0) begin
        m_bytes.delete();
        m_bytes.push_back(8'hA5);
        sum = 8'(m_buf.size());
        m_bytes.push_back(sum);
        foreach (m_buf[i]) begin
          m_bytes.push_back(m_buf[i]);
          sum = sum + m_buf[i];
        end
        m_bytes.push_back(8'h00 - sum);
        m_busy = 1; m_pend = 1; m_earliest = edge_n;
      end
      if (m_fin) begin
        m_fin = 0; m_busy = 0; m_buf.delete();
      end
      if (s_done && m_wait) begin
        m_wait = 0;
        if (m_bytes.size() > 0) begin
          m_pend = 1; m_earliest = edge_n + 1;
        end else begin
          exp_pd = 1; m_fin = 1;
        end
      end
      if (m_pend && edge_n >= m_earliest && !s_act) begin
        exp_dv = 1; exp_byte = m_bytes.pop_front();
        m_pend = 0; m_wait = 1;
      end
    end
    chk("tx_dv", o_Tx_DV, exp_dv);
    if (exp_dv) chk("tx_byte", o_Tx_Byte, exp_byte);
    chk("busy", o_Busy, m_busy);
    chk("buf_count", o_Buf_Count, m_buf.size());
    chk("buf_full", o_Buf_Full, m_buf.size() == 16);
    chk("wr_err", o_Wr_Err, exp_err);
    chk("pkt_done", o_Pkt_Done, exp_pd);
  end

  // Transmitter model: 10-cycle byte time, done pulse coincides with the line going idle.
  logic [7:0] tx_log[$];
  int  tx_cnt = 0, pkt_cnt = 0, gap_n = 0, gap_bad = 0;
  bit  gap_armed = 0, skip_done = 0;
  time t_done = 0, t_dv = 0, last_gap = 0, t_send = 0;

  always @(negedge clk) begin
    if (i_Reset) begin
      skip_done = 1; gap_armed = 0;
    end
    i_Tx_Done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        i_Tx_Done = 1'b1; t_done = $time;
        if (skip_done) skip_done = 0; else gap_armed = 1;
      end
    end
    if (o_Pkt_Done) begin
      pkt_cnt++; gap_armed = 0;
    end
    if (o_Tx_DV) begin
      tx_log.push_back(o_Tx_Byte);
      t_dv = $time; last_gap = $time - t_done;
      if (gap_armed) begin
        gap_n++;
        if (last_gap != 20) gap_bad++;
      end
      gap_armed = 0;
      tx_cnt = 10;
    end
    i_Tx_Active = (tx_cnt > 0);
  end

  task automatic wr(input logic [7:0] d);
    i_Wr_En = 1'b1; i_Wr_Data = d;
    @(negedge clk);
    i_Wr_En = 1'b0;
  endtask

  task automatic send();
    i_Send = 1'b1; t_send = $time;
    @(negedge clk);
    i_Send = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 400; i++) begin
      if (tx_log.size() >= n) break;
      @(negedge clk);
    end
    chk("log_wait", tx_log.size() >= n, 1);
  endtask

  task automatic wait_pkt(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (pkt_cnt >= n) break;
      @(negedge clk);
    end
    chk("pkt_wait", pkt_cnt >= n, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_bytes(input string name, input int base, input bq_t exp);
    chk({name, "_len"}, tx_log.size() - base, exp.size());
    foreach (exp[i]) begin
      if (base + i < tx_log.size()) chk(name, tx_log[base + i], exp[i]);
    end
  endtask

  initial begin
    bq_t e;
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t e;
    @(negedge clk);
    chk("reset_dv", o_Tx_DV, 0);
    chk("reset_busy", o_Busy, 0);
    chk("reset_count", o_Buf_Count, 0);
    chk("reset_full", o_Buf_Full, 0);
    chk("reset_err", o_Wr_Err, 0);
    chk("reset_pkt_done", o_Pkt_Done, 0);
    @(negedge clk);
    i_Reset = 1'b0;
    @(negedge clk);

    // basic three-byte packet
    wr(8'h01); wr(8'h02); wr(8'h03);
    send();
    wait_log(1);
    chk("send_to_sync_time", t_dv - t_send, 10);
    wait_pkt(1);
    e = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    chk_bytes("pkt_basic", 0, e);
    chk("count_after_pkt", o_Buf_Count, 0);
    chk("busy_after_pkt", o_Busy, 0);

    // send with empty buffer is ignored
    send();
    repeat (5) @(negedge clk);
    chk("empty_send_no_dv", tx_log.size(), 6);
    chk("empty_send_busy", o_Busy, 0);

    // fill to capacity, overflow, then write while busy
    for (int i = 0; i < 16; i++) wr(8'hFF);
    chk("full_flag", o_Buf_Full, 1);
    wr(8'hFF);
    chk("wr_err_full", o_Wr_Err, 1);
    chk("count_stays_16", o_Buf_Count, 16);
    send();
    repeat (30) @(negedge clk);
    wr(8'h55);
    chk("wr_err_busy", o_Wr_Err, 1);
    wait_pkt(2);
    e = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) e.push_back(8'hFF);
    e.push_back(8'h00);
    chk_bytes("pkt_full", 6, e);

    // write accepted in the same cycle as send
    wr(8'h07);
    i_Wr_En = 1'b1; i_Wr_Data = 8'h42; i_Send = 1'b1;
    @(negedge clk);
    i_Wr_En = 1'b0; i_Send = 1'b0;
    wait_pkt(3);
    e = '{8'hA5, 8'h02, 8'h07, 8'h42, 8'hB5};
    chk_bytes("pkt_same_cycle", 25, e);

    // reset during a DATA byte while the transmitter is still busy
    wr(8'h11); wr(8'h22); wr(8'h33);
    send();
    wait_log(33);
    @(negedge clk);
    i_Reset = 1'b1;
    #1;
    chk("midrst_dv", o_Tx_DV, 0);
    chk("midrst_busy", o_Busy, 0);
    chk("midrst_count", o_Buf_Count, 0);
    chk("midrst_tx_active", i_Tx_Active, 1);
    @(negedge clk); @(negedge clk);
    i_Reset = 1'b0;
    wr(8'h5A);
    send();
    wait_log(34);
    chk("post_rst_sync_after_idle", last_gap, 10);
    wait_pkt(4);
    e = '{8'hA5, 8'h01, 8'h5A, 8'hA5};
    chk_bytes("pkt_after_reset", 33, e);

    chk("done_to_dv_gap_errors", gap_bad, 0);
    chk("done_to_dv_gaps_seen", gap_n > 20, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
